// File: rtl/hd_miter_pkg.sv
// Shared types and helpers for the sequential Hamming-distance miter.
package hd_miter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } hd_state_e;

    function automatic int hd_width(input int width);
        return $clog2(width + 1);
    endfunction

    // Increment v, holding at the all-ones value of a w-bit counter.
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
        logic [63:0] lim;
        lim = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (v == lim) ? v : v + 64'd1;
    endfunction

endpackage

// File: rtl/hd_popcount.sv
// Combinational population count of an N-bit word.
module hd_popcount #(
    parameter int N = 16
) (
    input  logic [N-1:0]             x_i,
    output logic [$clog2(N+1)-1:0]   cnt_o
);

    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < N; i++) begin
            cnt_o = cnt_o + ($clog2(N+1))'(x_i[i]);
        end
    end

endmodule

// File: rtl/hd_miter_seq.sv
// Hamming-distance miter reducing a^b CHUNK bits per cycle, with threshold flag,
// optional early exit and a saturating failure counter.
module hd_miter_seq
    import hd_miter_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16,
    parameter int HD_W  = hd_width(WIDTH),
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [HD_W-1:0]  thr,
    input  logic             early_exit_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [HD_W-1:0]  hd,
    output logic             f,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output hd_state_e        state_o
);

    localparam int NBEAT  = WIDTH / CHUNK;
    localparam int BEAT_W = (NBEAT > 1) ? $clog2(NBEAT) : 1;
    localparam int PC_W   = $clog2(CHUNK + 1);

    generate
        if (WIDTH % CHUNK != 0) begin : g_bad_chunk
            $error("hd_miter_seq: CHUNK must divide WIDTH");
        end
    endgenerate

    hd_state_e          state_q, state_d;
    logic [WIDTH-1:0]   diff_q;
    logic [HD_W-1:0]    thr_q;
    logic               ee_q;
    logic [HD_W-1:0]    acc_q;
    logic [BEAT_W-1:0]  beat_q;
    logic [HD_W-1:0]    hd_q;
    logic               f_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [CHUNK-1:0]   chunk;
    logic [PC_W-1:0]    chunk_cnt;
    logic [HD_W-1:0]    acc_next;
    logic               scan_done;

    assign chunk     = diff_q[beat_q*CHUNK +: CHUNK];
    assign acc_next  = acc_q + HD_W'(chunk_cnt);
    assign scan_done = (beat_q == BEAT_W'(NBEAT - 1)) || (ee_q && (acc_next > thr_q));

    hd_popcount #(.N(CHUNK)) u_popcount (
        .x_i   (chunk),
        .cnt_o (chunk_cnt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = SCAN;
            SCAN:    if (scan_done) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // in_ready is gated by rst_n so nothing is accepted while reset is held.
    always_comb begin
        in_ready  = rst_n && (state_q == IDLE);
        out_valid = (state_q == DONE);
        hd        = hd_q;
        f         = f_q;
        err_cnt   = cnt_q;
        state_o   = state_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            diff_q <= '0;
            thr_q  <= '0;
            ee_q   <= 1'b0;
            acc_q  <= '0;
            beat_q <= '0;
            hd_q   <= '0;
            f_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    diff_q <= a ^ b;
                    thr_q  <= thr;
                    ee_q   <= early_exit_en;
                    acc_q  <= '0;
                    beat_q <= '0;
                end
                SCAN: begin
                    acc_q  <= acc_next;
                    beat_q <= beat_q + 1'b1;
                    if (scan_done) begin
                        hd_q <= acc_next;
                        f_q  <= (acc_next > thr_q);
                    end
                end
                default: ;
            endcase
        end
    end

    // Clear wins over a same-cycle failing handshake.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt)
            cnt_d = '0;
        else if (out_valid && out_ready && f_q)
            cnt_d = CNT_W'(sat_inc(64'(cnt_q), CNT_W));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule
